ifetch_prefetch_queue: RTL

Instruction prefetch stage between a variable-latency instruction memory port and the pipelined CPU's IF/ID register.
- Fetches sequential words ahead of the CPU with a single-outstanding req/ack port.
- Buffers {pc_add4, instr} pairs in a small FIFO and hands them to IF with valid/ready.
- A taken branch from MEM (redirect) flushes the queue and restarts fetch at the target.

---
 rtl/ifq_pkg.sv | 24 ++
 rtl/ifq_fifo.sv | 75 +++++++
 rtl/ifetch_prefetch_queue.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and constants for the instruction prefetch queue.
//   ifq_state_e : fetch FSM state (IDLE / REQ / DROP)
//   PTR_W       : queue pointer width for the default depth ($clog2(DEPTH))
//   ifq_entry_t : one queue entry, {pc_add4, instr}
//   ENTRY_W     : entry width (64)
package ifq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } ifq_state_e;

    // Default depth is 4 entries, so 2 pointer bits.
    localparam int unsigned PTR_W = 2;

    typedef struct packed {
        logic [31:0] pc_add4;
        logic [31:0] instr;
    } ifq_entry_t;

    localparam int unsigned ENTRY_W = $bits(ifq_entry_t);

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous FIFO holding fetched {pc_add4, instr} entries.
//   clk_i        clock
//   rst_i        synchronous active-low reset
//   flush_i      empty the queue at the edge (overrides push/pop)
//   push_i       write push_data_i at the tail
//   push_data_i  entry to write
//   pop_i        advance the head (ignored when empty)
//   head_o       entry at the head (fall-through read of storage)
//   count_o      occupancy, 0..DEPTH
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  ifq_entry_t               push_data_i,
    input  logic                     pop_i,
    output ifq_entry_t               head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW:0]        count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic               do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only occupied slots are ever observed.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// ifetch_prefetch_queue: sequential instruction prefetcher feeding IF.
//   clk_i, rst_i            clock, synchronous active-low reset
//   redirect_i/_pc_i        taken branch: flush queue, refetch at target
//   mem_req_o/_addr_o       single-outstanding fetch request (registered)
//   mem_ack_i/_rdata_i      transfer completion and instruction word
//   instr_valid_o/_o        queue head valid / head instruction
//   pc_add4_o               head fetch address + 4
//   instr_ready_i           IF accepts the head
//   count_o                 queue occupancy
module ifetch_prefetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH    = 1 << PTR_W,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic [31:0]              mem_rdata_i,
    output logic                     instr_valid_o,
    output logic [31:0]              instr_o,
    output logic [31:0]              pc_add4_o,
    input  logic                     instr_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

    ifq_state_e    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   addr_inc;
    logic          req_q, req_d;
    logic          push;
    logic          pop_fire;
    logic [CW-1:0] count;
    ifq_entry_t    push_data;
    ifq_entry_t    head;

    assign addr_inc  = addr_q + 32'd4;
    assign pop_fire  = instr_valid_o && instr_ready_i;
    assign push_data = '{pc_add4: addr_inc, instr: mem_rdata_i};

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    // Next state. A request launches only with a free slot after this edge,
    // so every ack is guaranteed room in the queue.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!redirect_i && ((count != FULL) || pop_fire)) state_d = REQ;
            end
            REQ: begin
                if (redirect_i)     state_d = mem_ack_i ? IDLE : DROP;
                else if (mem_ack_i) state_d = ((count == ALMOST) && !pop_fire) ? IDLE : REQ;
            end
            DROP: begin
                if (mem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and address bookkeeping
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect_i)          fetch_pc_d = redirect_pc_i;
                else if (state_d == REQ) addr_d     = fetch_pc_q;
            end
            REQ: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_i;
                end else if (mem_ack_i) begin
                    push       = 1'b1;
                    fetch_pc_d = addr_inc;
                    addr_d     = addr_inc;
                end
            end
            DROP: begin
                if (redirect_i) fetch_pc_d = redirect_pc_i;
            end
            default: ;
        endcase
        req_d = (state_d != IDLE);
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop_fire),
        .head_o      (head),
        .count_o     (count)
    );

    assign mem_req_o     = req_q;
    assign mem_addr_o    = addr_q;
    assign instr_valid_o = (count != '0);
    assign instr_o       = head.instr;
    assign pc_add4_o     = head.pc_add4;
    assign count_o       = count;

endmodule
